// File: rtl/snapshot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snapshot_pkg
// Description : Shared types for the conversion-result snapshot controller.
//               Holds the field widths, the controller state encoding and the
//               packed result record used for the snapshot and pending registers.
// Revision    : 1.0 - initial release
// ============================================================================
package snapshot_pkg;

    localparam int PWM_W   = 32;
    localparam int RD_W    = 12;
    localparam int SLOPE_W = 8;
    localparam int ERR_W   = 3;

    // Controller states with explicit 2-bit encoding
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        READY   = 2'd1,
        READING = 2'd2
    } state_e;

    // One finished conversion, as captured into the snapshot or pending buffer
    typedef struct packed {
        logic [PWM_W-1:0]   pwm_na;
        logic [PWM_W-1:0]   pwm_nb;
        logic [PWM_W-1:0]   pwm_pa;
        logic [PWM_W-1:0]   pwm_pb;
        logic [RD_W-1:0]    rundown;
        logic [SLOPE_W-1:0] n64;
        logic [SLOPE_W-1:0] p8;
        logic [SLOPE_W-1:0] n1;
        logic [ERR_W-1:0]   err;
    } result_t;

endpackage
`default_nettype wire

// File: rtl/result_snapshot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : result_snapshot_ctrl_if
// Description : Converter-side result bus, host-side chip select / NPLC request
//               and the snapshot outputs toward the SPI readout shifter.
//               master = converter/host side, slave = snapshot controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_snapshot_ctrl_if #(
    parameter int NPLC_W = 10,
    parameter int OVR_W  = 4
);
    // Converter result bus
    logic                                conv_done;
    logic [snapshot_pkg::PWM_W-1:0]      inNA, inNB, inPA, inPB;
    logic [snapshot_pkg::RD_W-1:0]       inRundown;
    logic [snapshot_pkg::SLOPE_W-1:0]    inN64, inP8, inN1;
    logic [snapshot_pkg::ERR_W-1:0]      inError;
    // Host side
    logic                                cs;
    logic [NPLC_W-1:0]                   nplc_req;
    // Snapshot toward the SPI shifter
    logic [snapshot_pkg::PWM_W-1:0]      stpwmNA, stpwmNB, stpwmPA, stpwmPB;
    logic [snapshot_pkg::RD_W-1:0]       strundown;
    logic [snapshot_pkg::SLOPE_W-1:0]    stN64, stP8, stN1;
    logic [snapshot_pkg::ERR_W-1:0]      sterror;
    logic [7:0]                          seq;
    logic                                drdy;
    logic [NPLC_W-1:0]                   nplc_active;
    logic [OVR_W-1:0]                    overrun_cnt;

    modport master (
        output conv_done, inNA, inNB, inPA, inPB, inRundown, inN64, inP8, inN1,
               inError, cs, nplc_req,
        input  stpwmNA, stpwmNB, stpwmPA, stpwmPB, strundown, stN64, stP8, stN1,
               sterror, seq, drdy, nplc_active, overrun_cnt
    );

    modport slave (
        input  conv_done, inNA, inNB, inPA, inPB, inRundown, inN64, inP8, inN1,
               inError, cs, nplc_req,
        output stpwmNA, stpwmNB, stpwmPA, stpwmPB, strundown, stN64, stP8, stN1,
               sterror, seq, drdy, nplc_active, overrun_cnt
    );

endinterface
`default_nettype wire

// File: rtl/cs_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : cs_sync_edge
// Description : Two-flop synchroniser for the host chip select plus one history
//               stage, producing single-cycle fall/rise pulses of the
//               synchronised select. Idles (and resets) deselected/high.
// Revision    : 1.0 - initial release
// ============================================================================
module cs_sync_edge (
    input  wire  msclk,
    input  wire  rst,
    input  wire  cs_async,
    output logic cs_fall,
    output logic cs_rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the raw select through the synchroniser and one history stage
    always_comb begin
        meta_d = cs_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // All stages reset to the deselected level so no edge appears at reset exit
    always_ff @(posedge msclk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign cs_fall =  prev_q & ~sync_q;
    assign cs_rise = ~prev_q &  sync_q;

endmodule
`default_nettype wire

// File: rtl/result_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : result_snapshot_ctrl
// Description : Captures finished conversions into a stable snapshot for SPI
//               readout, raises drdy, freezes the snapshot while the host reads
//               (parking one newer result), counts lost results and applies
//               NPLC changes only on conversion boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module result_snapshot_ctrl
    import snapshot_pkg::*;
#(
    parameter int NPLC_W   = 10,
    parameter int OVR_W    = 4,
    parameter int NPLC_RST = 2
) (
    input  wire                    msclk,
    input  wire                    rst,
    result_snapshot_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    result_t           snap_q, snap_d;
    result_t           pend_q, pend_d;
    result_t           new_res;
    logic              pend_valid_q, pend_valid_d;
    logic [7:0]        seq_q, seq_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d, ovr_inc;
    logic [NPLC_W-1:0] nplc_q, nplc_d;
    logic              cs_fall, cs_rise;

    cs_sync_edge u_cs_sync (
        .msclk    (msclk),
        .rst      (rst),
        .cs_async (bus.cs),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise)
    );

    assign new_res = '{pwm_na:  bus.inNA,      pwm_nb: bus.inNB,
                       pwm_pa:  bus.inPA,      pwm_pb: bus.inPB,
                       rundown: bus.inRundown, n64:    bus.inN64,
                       p8:      bus.inP8,      n1:     bus.inN1,
                       err:     bus.inError};

    // Lost-result counter sticks at all-ones
    assign ovr_inc = (&ovr_q) ? ovr_q : ovr_q + OVR_W'(1);

    // Hand-off sequencing: snapshot only changes outside READING
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        seq_d        = seq_q;
        ovr_d        = ovr_q;
        unique case (state_q)
            EMPTY, READY: begin
                if (cs_fall) begin
                    // Host read starts; a coincident result is parked, not shown
                    state_d = READING;
                    if (bus.conv_done) begin
                        pend_d       = new_res;
                        pend_valid_d = 1'b1;
                    end
                end else if (bus.conv_done) begin
                    snap_d  = new_res;
                    seq_d   = seq_q + 8'd1;
                    state_d = READY;
                    if (state_q == READY) begin
                        ovr_d = ovr_inc;
                    end
                end
            end
            READING: begin
                if (cs_rise) begin
                    pend_valid_d = 1'b0;
                    if (bus.conv_done) begin
                        // Freshest result wins; a parked one is dropped
                        snap_d  = new_res;
                        seq_d   = seq_q + 8'd1;
                        state_d = READY;
                        if (pend_valid_q) begin
                            ovr_d = ovr_inc;
                        end
                    end else if (pend_valid_q) begin
                        snap_d  = pend_q;
                        seq_d   = seq_q + 8'd1;
                        state_d = READY;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (bus.conv_done) begin
                    pend_d       = new_res;
                    pend_valid_d = 1'b1;
                    if (pend_valid_q) begin
                        ovr_d = ovr_inc;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // NPLC is only taken at a conversion boundary; zero requests are ignored
    always_comb begin
        nplc_d = nplc_q;
        if (bus.conv_done && (bus.nplc_req != '0)) begin
            nplc_d = bus.nplc_req;
        end
    end

    // State, snapshot, pending buffer and counters
    always_ff @(posedge msclk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            snap_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            seq_q        <= 8'd0;
            ovr_q        <= '0;
            nplc_q       <= NPLC_W'(NPLC_RST);
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seq_q        <= seq_d;
            ovr_q        <= ovr_d;
            nplc_q       <= nplc_d;
        end
    end

    assign bus.stpwmNA     = snap_q.pwm_na;
    assign bus.stpwmNB     = snap_q.pwm_nb;
    assign bus.stpwmPA     = snap_q.pwm_pa;
    assign bus.stpwmPB     = snap_q.pwm_pb;
    assign bus.strundown   = snap_q.rundown;
    assign bus.stN64       = snap_q.n64;
    assign bus.stP8        = snap_q.p8;
    assign bus.stN1        = snap_q.n1;
    assign bus.sterror     = snap_q.err;
    assign bus.seq         = seq_q;
    assign bus.drdy        = (state_q == READY);
    assign bus.nplc_active = nplc_q;
    assign bus.overrun_cnt = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_result_snapshot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_snapshot_ctrl
// Description : Self-checking bench for result_snapshot_ctrl: directed vector
//               table, async-reset sequence and random traffic against an
//               event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_snapshot_ctrl;
    import snapshot_pkg::*;

    localparam int NPLC_W   = 10;
    localparam int OVR_W    = 4;
    localparam int NPLC_RST = 2;
    localparam int OVR_MAX  = (1 << OVR_W) - 1;

    logic msclk = 1'b0;
    logic rst   = 1'b0;
    always #5 msclk = ~msclk;

    result_snapshot_ctrl_if #(.NPLC_W(NPLC_W), .OVR_W(OVR_W)) bus ();

    result_snapshot_ctrl #(.NPLC_W(NPLC_W), .OVR_W(OVR_W), .NPLC_RST(NPLC_RST)) dut (
        .msclk (msclk),
        .rst   (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model state ----------------
    result_t m_snap;
    result_t m_pend[$];
    int      m_seq, m_ovr, m_nplc;
    bit      m_reading, m_unread;
    bit      h1, h2, h3;     // cs as sampled at the last three clock edges

    typedef struct {
        bit          conv;
        logic [31:0] na;
        bit          cs;
        logic [9:0]  req;
        logic [31:0] e_na;
        logic [7:0]  e_seq;
        bit          e_drdy;
        logic [3:0]  e_ovr;
        logic [9:0]  e_nplc;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic result_t mk_res(input logic [31:0] na);
        result_t r;
        r.pwm_na  = na;
        r.pwm_nb  = na ^ 32'hA5A5_0000;
        r.pwm_pa  = na + 32'd1;
        r.pwm_pb  = ~na;
        r.rundown = na[11:0];
        r.n64     = na[7:0] ^ 8'h5A;
        r.p8      = 8'h11;
        r.n1      = na[15:8];
        r.err     = na[2:0];
        return r;
    endfunction

    function automatic vec_t mk_vec(input bit conv, input logic [31:0] na, input bit cs,
                                    input logic [9:0] req, input logic [31:0] e_na,
                                    input logic [7:0] e_seq, input bit e_drdy,
                                    input logic [3:0] e_ovr, input logic [9:0] e_nplc);
        vec_t v;
        v.conv = conv; v.na = na; v.cs = cs; v.req = req;
        v.e_na = e_na; v.e_seq = e_seq; v.e_drdy = e_drdy; v.e_ovr = e_ovr; v.e_nplc = e_nplc;
        return v;
    endfunction

    task automatic drive(input bit conv, input result_t r, input bit cs_v, input logic [9:0] req);
        bus.conv_done = conv;
        bus.inNA      = r.pwm_na;
        bus.inNB      = r.pwm_nb;
        bus.inPA      = r.pwm_pa;
        bus.inPB      = r.pwm_pb;
        bus.inRundown = r.rundown;
        bus.inN64     = r.n64;
        bus.inP8      = r.p8;
        bus.inN1      = r.n1;
        bus.inError   = r.err;
        bus.cs        = cs_v;
        bus.nplc_req  = req;
    endtask

    task automatic model_reset();
        m_snap = '0;
        m_pend.delete();
        m_seq = 0; m_ovr = 0; m_nplc = NPLC_RST;
        m_reading = 1'b0; m_unread = 1'b0;
        h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    endtask

    function automatic int sat(input int v);
        return (v < OVR_MAX) ? v + 1 : OVR_MAX;
    endfunction

    // Apply one clock edge worth of the readout rules to the model
    task automatic model_edge();
        bit      fall, rise, conv;
        result_t r;
        fall = h3 && !h2;
        rise = !h3 && h2;
        conv = bus.conv_done;
        r = '{pwm_na: bus.inNA, pwm_nb: bus.inNB, pwm_pa: bus.inPA, pwm_pb: bus.inPB,
              rundown: bus.inRundown, n64: bus.inN64, p8: bus.inP8, n1: bus.inN1,
              err: bus.inError};
        if (!m_reading) begin
            if (fall) begin
                m_reading = 1'b1;
                m_unread  = 1'b0;
                if (conv) begin
                    if (m_pend.size() != 0) m_ovr = sat(m_ovr);
                    m_pend.delete();
                    m_pend.push_back(r);
                end
            end else if (conv) begin
                if (m_unread) m_ovr = sat(m_ovr);
                m_snap   = r;
                m_seq    = (m_seq + 1) % 256;
                m_unread = 1'b1;
            end
        end else begin
            if (rise) begin
                m_reading = 1'b0;
                if (conv) begin
                    if (m_pend.size() != 0) m_ovr = sat(m_ovr);
                    m_pend.delete();
                    m_snap   = r;
                    m_seq    = (m_seq + 1) % 256;
                    m_unread = 1'b1;
                end else if (m_pend.size() != 0) begin
                    m_snap   = m_pend.pop_front();
                    m_seq    = (m_seq + 1) % 256;
                    m_unread = 1'b1;
                end else begin
                    m_unread = 1'b0;
                end
            end else if (conv) begin
                if (m_pend.size() != 0) m_ovr = sat(m_ovr);
                m_pend.delete();
                m_pend.push_back(r);
            end
        end
        if (conv && bus.nplc_req != '0) m_nplc = int'(bus.nplc_req);
        h3 = h2; h2 = h1; h1 = bus.cs;
    endtask

    task automatic check_model();
        logic [166:0] act_snap;
        act_snap = {bus.stpwmNA, bus.stpwmNB, bus.stpwmPA, bus.stpwmPB, bus.strundown,
                    bus.stN64, bus.stP8, bus.stN1, bus.sterror};
        chk("model.snapshot",   act_snap,           m_snap);
        chk("model.seq",        bus.seq,            m_seq);
        chk("model.drdy",       bus.drdy,           (m_unread && !m_reading));
        chk("model.overrun",    bus.overrun_cnt,    m_ovr);
        chk("model.nplc",       bus.nplc_active,    m_nplc);
        chk("model.pend_valid", dut.pend_valid_q,   (m_pend.size() != 0));
    endtask

    task automatic step();
        model_edge();
        @(posedge msclk);
        #1;
        check_model();
    endtask

    initial begin
        int cs_left;
        bit cs_v;
        result_t r;

        // Directed table: one row per clock, expected values after that edge
        vecs[0]  = mk_vec(1, 32'h1234, 1,   0, 32'h1234, 1, 1, 0,   2);
        vecs[1]  = mk_vec(0, 32'h0,    1, 100, 32'h1234, 1, 1, 0,   2);
        vecs[2]  = mk_vec(1, 32'd5,    1, 100, 32'd5,    2, 1, 1, 100);
        vecs[3]  = mk_vec(1, 32'd7,    1,   0, 32'd7,    3, 1, 2, 100);
        vecs[4]  = mk_vec(0, 32'h0,    0,   0, 32'd7,    3, 1, 2, 100);
        vecs[5]  = mk_vec(0, 32'h0,    0,   0, 32'd7,    3, 1, 2, 100);
        vecs[6]  = mk_vec(0, 32'h0,    0,   0, 32'd7,    3, 0, 2, 100);
        vecs[7]  = mk_vec(1, 32'd9,    0,   0, 32'd7,    3, 0, 2, 100);
        vecs[8]  = mk_vec(1, 32'd10,   0,   0, 32'd7,    3, 0, 3, 100);
        vecs[9]  = mk_vec(1, 32'd11,   0,   0, 32'd7,    3, 0, 4, 100);
        vecs[10] = mk_vec(0, 32'h0,    1,   0, 32'd7,    3, 0, 4, 100);
        vecs[11] = mk_vec(0, 32'h0,    1,   0, 32'd7,    3, 0, 4, 100);
        vecs[12] = mk_vec(0, 32'h0,    1,   0, 32'd11,   4, 1, 4, 100);
        vecs[13] = mk_vec(0, 32'h0,    0,   0, 32'd11,   4, 1, 4, 100);
        vecs[14] = mk_vec(0, 32'h0,    0,   0, 32'd11,   4, 1, 4, 100);
        vecs[15] = mk_vec(0, 32'h0,    0,   0, 32'd11,   4, 0, 4, 100);
        vecs[16] = mk_vec(1, 32'd20,   1,   0, 32'd11,   4, 0, 4, 100);
        vecs[17] = mk_vec(0, 32'h0,    1,   0, 32'd11,   4, 0, 4, 100);
        vecs[18] = mk_vec(1, 32'd30,   1,   0, 32'd30,   5, 1, 5, 100);
        vecs[19] = mk_vec(0, 32'h0,    1,   0, 32'd30,   5, 1, 5, 100);
        vecs[20] = mk_vec(0, 32'h0,    0,   0, 32'd30,   5, 1, 5, 100);
        vecs[21] = mk_vec(0, 32'h0,    0,   0, 32'd30,   5, 1, 5, 100);
        vecs[22] = mk_vec(1, 32'd40,   0,   0, 32'd30,   5, 0, 5, 100);
        vecs[23] = mk_vec(0, 32'h0,    1,   0, 32'd30,   5, 0, 5, 100);
        vecs[24] = mk_vec(0, 32'h0,    1,   0, 32'd30,   5, 0, 5, 100);
        vecs[25] = mk_vec(0, 32'h0,    1,   0, 32'd40,   6, 1, 5, 100);
        vecs[26] = mk_vec(0, 32'h0,    1,   0, 32'd40,   6, 1, 5, 100);

        // Reset state
        drive(1'b0, '0, 1'b1, '0);
        model_reset();
        repeat (3) @(posedge msclk);
        #1;
        chk("reset.stpwmNA", bus.stpwmNA,     32'h0);
        chk("reset.seq",     bus.seq,         8'd0);
        chk("reset.drdy",    bus.drdy,        1'b0);
        chk("reset.ovr",     bus.overrun_cnt, 4'd0);
        chk("reset.nplc",    bus.nplc_active, 10'd2);
        check_model();
        rst = 1'b1;

        // Directed vectors
        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].conv, mk_res(vecs[i].na), vecs[i].cs, vecs[i].req);
            step();
            chk($sformatf("vec%0d.stpwmNA", i), bus.stpwmNA,     vecs[i].e_na);
            chk($sformatf("vec%0d.seq", i),     bus.seq,         vecs[i].e_seq);
            chk($sformatf("vec%0d.drdy", i),    bus.drdy,        vecs[i].e_drdy);
            chk($sformatf("vec%0d.ovr", i),     bus.overrun_cnt, vecs[i].e_ovr);
            chk($sformatf("vec%0d.nplc", i),    bus.nplc_active, vecs[i].e_nplc);
            if (i == 12) chk("vec12.pend_valid", dut.pend_valid_q, 1'b0);
        end

        // Async reset in the middle of a read with a parked result
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b0, '0);
            step();
        end
        drive(1'b1, mk_res(32'h55), 1'b0, 10'd77);
        step();
        drive(1'b0, '0, 1'b0, '0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.stpwmNA", bus.stpwmNA,     32'h0);
        chk("arst.seq",     bus.seq,         8'd0);
        chk("arst.drdy",    bus.drdy,        1'b0);
        chk("arst.ovr",     bus.overrun_cnt, 4'd0);
        chk("arst.nplc",    bus.nplc_active, 10'd2);
        chk("arst.pend",    dut.pend_valid_q, 1'b0);
        model_reset();
        drive(1'b0, '0, 1'b1, '0);
        @(posedge msclk);
        #1;
        rst = 1'b1;
        check_model();

        // Random traffic against the model
        cs_v    = 1'b1;
        cs_left = 4;
        for (int n = 0; n < 3000; n++) begin
            if (cs_left == 0) begin
                cs_v    = ~cs_v;
                cs_left = $urandom_range(1, 8);
            end
            cs_left--;
            r = '{pwm_na: $urandom, pwm_nb: $urandom, pwm_pa: $urandom, pwm_pb: $urandom,
                  rundown: 12'($urandom), n64: 8'($urandom), p8: 8'($urandom),
                  n1: 8'($urandom), err: 3'($urandom)};
            drive(($urandom_range(0, 2) == 0), r, cs_v,
                  ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_snapshot_ctrl.md
Name: result_snapshot_ctrl

Overview:
- Sequences hand-off of multi-slope conversion results to the SPI readout shifter.
- Captures each finished conversion into a stable snapshot, and raises data-ready (drdy) for the host.
- Freezes the snapshot while the host is reading (cs low), and parks one newer result in a pending buffer.
- Applies host-requested NPLC changes only at conversion boundaries; counts lost results.

Parameters:
- NPLC_W, 10, width of NPLC setting
- OVR_W, 4, width of saturating overrun counter
- NPLC_RST, 2, nplc_active value after reset

Ports:
- msclk  in  1  system clock; one clock
- rst  in  1  reset, asynchronous, active-low
- conv_done  in  1  one-cycle pulse from converter: in* result buses valid this cycle
- inNA, inNB, inPA, inPB  in  32 each  PWM phase counts of finished conversion
- inRundown  in  12  rundown count
- inN64, inP8, inN1  in  8 each  slope counts
- inError  in  3  converter error flags
- cs  in  1  raw SPI chip select from host (asynchronous to msclk)
- nplc_req  in  NPLC_W  NPLC value written by host via SPI
- stpwmNA, stpwmNB, stpwmPA, stpwmPB  out  32 each  snapshot to SPI shifter
- strundown  out  12; stN64, stP8, stN1  out  8 each; sterror  out  3  snapshot fields
- seq  out  8  snapshot sequence number, +1 per conversion captured (wraps 255->0)
- drdy  out  1  data-ready to host
- nplc_active  out  NPLC_W  NPLC used by converter
- overrun_cnt  out  OVR_W  saturating count of discarded results

Behaviour:
- Reset (rst low, async): all st* = 0, seq = 0, drdy = 0, overrun_cnt = 0, nplc_active = NPLC_RST, pend_valid = 0, state = EMPTY.
- cs passes a 2-flop synchroniser; cs_fall/cs_rise are single-cycle edges of the synchronised signal; cs_sync resets to 1.
- States:
  - EMPTY: no unread data.
  - READY: unread snapshot, drdy = 1.
  - READING: cs_sync low.
- Transitions:
  - EMPTY + conv_done -> load snapshot, seq+1, READY; drdy = 1 next cycle (1-cycle latency).
  - READY + conv_done -> overwrite snapshot, seq+1, overrun_cnt+1 (saturating), stay READY.
  - EMPTY/READY + cs_fall -> READING, drdy = 0 next cycle.
  - READING + conv_done -> write pending buffer. Snapshot outputs are unchanged. If pend_valid was already 1, overwrite the buffer and do overrun_cnt+1. Set pend_valid = 1.
  - READING + cs_rise:
    - pend_valid = 1 -> promote pending to snapshot, seq+1, pend_valid = 0, READY, drdy = 1.
    - pend_valid = 0 -> EMPTY.
- Simultaneous events:
  - conv_done and cs_fall in the same cycle: cs_fall takes priority; state -> READING and the result goes to the pending buffer.
  - conv_done and cs_rise in the same cycle: the new result loads the snapshot directly (seq+1), state -> READY. If pend_valid was 1, discard the pending result, do overrun_cnt+1, and clear pend_valid.
- Snapshot invariant: st* and seq never change while state = READING.
- NPLC: nplc_active <= nplc_req only in a cycle with conv_done = 1. A value of 0 in nplc_req is ignored; nplc_active is kept.
- overrun_cnt saturates at all-ones; it clears only on reset.
- Glitch on cs shorter than 2 msclk may be missed; this is acceptable.

Decomposition:
- Package snapshot_pkg holds:
  - state enum {EMPTY, READY, READING}
  - field widths (PWM_W = 32, RD_W = 12, SLOPE_W = 8, ERR_W = 3)
  - packed result struct used for both the snapshot and pending registers
- One sub-module: cs_sync_edge (2-flop synchroniser plus fall/rise pulse outputs, async active-low reset to synced-high).

Test Plan:
- Reset, then conv_done with inNA = 32'h0000_1234 -> next cycle stpwmNA = 32'h1234, seq = 1, drdy = 1, overrun_cnt = 0.
- Two conv_done with no read (inNA = 5, then 7) -> stpwmNA = 7, seq = 2, overrun_cnt = 1.
- cs low, conv_done (inNA = 9) during read; stpwmNA stays at the old value. cs high -> 2-3 cycles later stpwmNA = 9, drdy = 1, pend_valid = 0.
- Three conv_done while cs low -> overrun_cnt +2; after cs rise the snapshot holds the third result.
- nplc_req = 100 with no conv_done -> nplc_active stays 2. Then conv_done -> nplc_active = 100. Then nplc_req = 0 plus conv_done -> nplc_active stays 100.
- conv_done in the same cycle as cs_rise with pend_valid = 1 -> snapshot = new result, overrun_cnt +1. Separately, assert rst mid-READING -> all outputs immediately take reset values asynchronously.
